quad_traffic_gen: RTL
=====================

# quad_traffic_gen

Closed-loop traffic generator and result checker for the quadratic solver pipeline Y = A·x² + B·x + C. The transmit side drives a sequence of x operands into the pipeline's input handshake. The receive side accepts Y results from the pipeline's output handshake and compares them in order against golden values. Golden values are computed at send time and held in an internal expected-value FIFO. The block sits at both ends of the solver chain in the NoC test designs and reports pass/fail plus an error count.

## Interface
- `WIDTH`, 16, operand/result width
- `A`, 16'd101, quadratic coefficient
- `B`, 16'd59, linear coefficient
- `C`, 16'd76, constant coefficient
- `NUM_X`, 16, operands per run (1..65535)
- `FIFO_DEPTH`, 8, expected-value FIFO entries (power of 2, ≥2)
- `X_START`, 16'd0, first operand in counter mode

- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: single-cycle pulse; begins a run when idle or done
- `o_x` out WIDTH: operand to pipeline
- `o_valid_out` out 1: operand valid
- `o_ready_in` in 1: pipeline ready to accept operand
- `i_y` in WIDTH: result from pipeline
- `i_valid_in` in 1: result valid
- `i_ready_out` out 1: checker ready to accept result
- `o_busy` out 1: run in progress
- `o_done` out 1: run complete; sticky until next start or reset
- `o_pass` out 1: valid when o_done; 1 iff err_cnt==0
- `o_err_cnt` out 16: mismatches plus unexpected results; saturates at 16'hFFFF

## Operation
- Reset: FSM=IDLE. o_x=0, o_valid_out=0, i_ready_out=0, o_busy=0, o_done=0, o_pass=0, o_err_cnt=0. FIFO empty; counters cleared.
- FSM states:
  - IDLE: start → RUN. On entry to RUN: clear err_cnt, sent_cnt, recv_cnt, and FIFO. Load x=X_START.
  - RUN: sending and checking proceed independently. When recv_cnt==NUM_X and sent_cnt==NUM_X, go to DONE.
  - DONE: o_done=1, o_pass=(err_cnt==0). start → RUN, with the same clears.
  - start is ignored while in RUN.
- Send transfer occurs when o_valid_out & o_ready_in are high at a clock edge.
- o_valid_out is high in RUN when sent_cnt<NUM_X and the FIFO is not full.
- o_x and o_valid_out are registered. o_x is held stable while o_valid_out=1 and o_ready_in=0.
- On each send: push exp = (A·x·x + B·x + C) mod 2^WIDTH. Products are computed at 2·WIDTH bits and then truncated. Then increment x (wraps mod 2^WIDTH) and sent_cnt.
- i_ready_out = 1 in RUN and DONE, 0 in IDLE and during reset.
- Receive transfer occurs when i_valid_in & i_ready_out are high.
  - FIFO non-empty: pop the head and compare with i_y. Mismatch → err_cnt+1. Increment recv_cnt.
  - FIFO empty (unexpected result, including any result in DONE): err_cnt+1. recv_cnt is unchanged.
- FIFO full with a simultaneous receive pop: the send is still blocked that cycle, because o_valid_out was already registered low. Push and pop in the same cycle on a non-full FIFO are both performed.
- err_cnt saturates at 16'hFFFF and never wraps.
- rst asserted mid-run: everything returns to reset values at the next edge, and in-flight expected values are discarded.

## Timing
- start sampled in cycle T → o_busy=1 and o_valid_out=1 at T+1 with o_x=X_START.
- Back-to-back sends at 1 operand/cycle while o_ready_in=1 and the FIFO is not full.
- FIFO becomes non-full at edge E → o_valid_out can reassert at E+1.
- Compare result and err_cnt update are visible one cycle after the receive transfer.
- Final receive at edge E → o_done=1, o_busy=0, o_pass valid at E+1.
- Maximum outstanding operands = FIFO_DEPTH.

## Configuration
- `QUAD_TRAFFIC_GEN_LFSR_EN` defined: the operand sequence comes from a WIDTH-bit Galois LFSR seeded with X_START. A seed of 0 is forced to 1. The polynomial for WIDTH=16 is x^16+x^14+x^13+x^11+1. The LFSR advances on each send.
- `QUAD_TRAFFIC_GEN_LFSR_EN` undefined: operands are the incrementing sequence X_START, X_START+1, … (wraps mod 2^WIDTH).
- Checking, FIFO and FSM are identical in both builds.

## Test plan
- Loopback model with 1-cycle latency, default parameters, NUM_X=4, counter mode: o_x=0,1,2,3; expected Y=76,236,598,1162 → o_done=1, o_pass=1, o_err_cnt=0 at 1 cycle after the 4th result.
- Same setup with the model corrupting the Y for x=2 (returns 599) → o_pass=0, o_err_cnt=1.
- o_ready_in held low for 5 cycles mid-run → o_x stable, no duplicate or skipped operands, pass.
- Sink stalls results for 20 cycles, FIFO_DEPTH=8 → exactly 8 sends, then o_valid_out=0 until the first pop; pass.
- Extra unsolicited result injected with the FIFO empty, and one more in DONE → o_err_cnt=2.
- rst pulsed after 2 sends → all outputs at reset values next cycle. A new start → a clean run that passes.

Source files
------------

// File: rtl/quad_traffic_gen_if.sv
// Operand/result handshake bundle between the traffic generator (master) and the solver pipeline (slave).
interface quad_traffic_gen_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] o_x;
    logic             o_valid_out;
    logic             o_ready_in;
    logic [WIDTH-1:0] i_y;
    logic             i_valid_in;
    logic             i_ready_out;

    modport master (
        output o_x, o_valid_out, i_ready_out,
        input  o_ready_in, i_y, i_valid_in
    );

    modport slave (
        input  o_x, o_valid_out, i_ready_out,
        output o_ready_in, i_y, i_valid_in
    );
endinterface

// File: rtl/quad_traffic_gen.sv
// Closed-loop traffic generator/checker for Y = A*x^2 + B*x + C with an in-order expected-value FIFO.
// Define QUAD_TRAFFIC_GEN_LFSR_EN to draw operands from a Galois LFSR instead of an incrementing counter.
module quad_traffic_gen #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] A          = 'd101,
    parameter logic [WIDTH-1:0] B          = 'd59,
    parameter logic [WIDTH-1:0] C          = 'd76,
    parameter int               NUM_X      = 16,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] X_START    = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    quad_traffic_gen_if.master  bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [15:0]         o_err_cnt
);
    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam int              PW2     = 2 * WIDTH;
    localparam logic [15:0]     NUM_X_C = 16'(NUM_X);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, x_next, exp_y;
    logic             valid_q, valid_d, ready_q, ready_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]      sent_cnt_q, sent_cnt_d, recv_cnt_q, recv_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic             send, recv, pop, bad_result;
    logic [PW2-1:0]   x_wide;

`ifdef QUAD_TRAFFIC_GEN_LFSR_EN
    // Galois form of x^16+x^14+x^13+x^11+1; an all-zero seed would lock up, so it becomes 1.
    localparam logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(16'hB400);
    localparam logic [WIDTH-1:0] X_SEED    = (X_START == '0) ? WIDTH'(1) : X_START;
    assign x_next = (x_q >> 1) ^ (x_q[0] ? LFSR_TAPS : '0);
`else
    localparam logic [WIDTH-1:0] X_SEED    = X_START;
    assign x_next = x_q + WIDTH'(1);
`endif

    assign x_wide = PW2'(x_q);
    assign exp_y  = WIDTH'(PW2'(A) * x_wide * x_wide + PW2'(B) * x_wide + PW2'(C));

    assign send       = valid_q & bus.o_ready_in;
    assign recv       = bus.i_valid_in & ready_q;
    assign pop        = recv && (count_q != '0);
    assign bad_result = recv && (!pop || (fifo_mem_q[rd_ptr_q] != bus.i_y));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        sent_cnt_d = sent_cnt_q;
        recv_cnt_d = recv_cnt_q;
        err_cnt_d  = err_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (send) begin
            x_d        = x_next;
            sent_cnt_d = sent_cnt_q + 16'd1;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            recv_cnt_d = recv_cnt_q + 16'd1;
        end
        if (send && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !send) begin
            count_d = count_q - CNT_W'(1);
        end
        if (bad_result && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // A new run discards everything left over, including results that arrived in the same cycle.
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    x_d        = X_SEED;
                    sent_cnt_d = '0;
                    recv_cnt_d = '0;
                    err_cnt_d  = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                end
            end
            RUN: begin
                if ((sent_cnt_d == NUM_X_C) && (recv_cnt_d == NUM_X_C)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == RUN) && (sent_cnt_d < NUM_X_C) && (count_d < DEPTH_C);
        ready_d = (state_d != IDLE);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
        pass_d  = (state_d == DONE) && (err_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            sent_cnt_q <= '0;
            recv_cnt_q <= '0;
            err_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            sent_cnt_q <= sent_cnt_d;
            recv_cnt_q <= recv_cnt_d;
            err_cnt_q  <= err_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (send) begin
            fifo_mem_q[wr_ptr_q] <= exp_y;
        end
    end

    assign bus.o_x         = x_q;
    assign bus.o_valid_out = valid_q;
    assign bus.i_ready_out = ready_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_pass          = pass_q;
    assign o_err_cnt       = err_cnt_q;
endmodule
